// File: rtl/bcd_counter_n.sv
// bcd_counter_n: registered N-digit BCD up/down counter with load/clear.
// Option BCD_COUNTER_SATURATE_EN: clamp at all-9s/all-0s instead of wrap.
module bcd_counter_n #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                inc,
  input  logic                dec,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic                borrow,
  output logic                at_max,
  output logic                at_zero,
  output logic                load_err
);

  localparam int W = 4*DIGITS;

  logic [W-1:0]             r_count;
  logic                     r_carry;
  logic                     r_borrow;
  logic                     r_load_err;

  logic [DIGITS-1:0][3:0]   w_dig;
  logic [DIGITS:0]          w_lo9;
  logic [DIGITS:0]          w_lo0;
  logic [DIGITS-1:0]        w_ld_bad;
  logic [DIGITS-1:0]        w_raw9;
  logic [DIGITS-1:0]        w_raw0;
  logic [W-1:0]             w_ld;
  logic [W-1:0]             w_up;
  logic [W-1:0]             w_dn;
  logic [W-1:0]             w_up_nx;
  logic [W-1:0]             w_dn_nx;
  logic                     w_all9;
  logic                     w_all0;
  logic                     w_step_up;
  logic                     w_step_dn;

  assign w_lo9[0] = 1'b1;
  assign w_lo0[0] = 1'b1;

  // Per-digit sanitising and ripple chains.
  // w_lo9[k]/w_lo0[k]: every digit below k is 9 / 0.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign w_dig[k] =
      (r_count[4*k +: 4] > 4'd9) ? 4'd9
                                 : r_count[4*k +: 4];

    assign w_ld_bad[k] = load_val[4*k +: 4] > 4'd9;

    assign w_ld[4*k +: 4] =
      w_ld_bad[k] ? 4'd9 : load_val[4*k +: 4];

    assign w_lo9[k+1] = w_lo9[k] & (w_dig[k] == 4'd9);
    assign w_lo0[k+1] = w_lo0[k] & (w_dig[k] == 4'd0);

    assign w_up[4*k +: 4] =
      !w_lo9[k]          ? w_dig[k] :
      (w_dig[k] == 4'd9) ? 4'd0
                         : w_dig[k] + 4'd1;

    assign w_dn[4*k +: 4] =
      !w_lo0[k]          ? w_dig[k] :
      (w_dig[k] == 4'd0) ? 4'd9
                         : w_dig[k] - 4'd1;

    assign w_raw9[k] = r_count[4*k +: 4] == 4'd9;
    assign w_raw0[k] = r_count[4*k +: 4] == 4'd0;
  end

  assign w_all9 = w_lo9[DIGITS];
  assign w_all0 = w_lo0[DIGITS];

  assign w_step_up = inc & ~dec;
  assign w_step_dn = dec & ~inc;

`ifdef BCD_COUNTER_SATURATE_EN
  assign w_up_nx = w_all9 ? r_count : w_up;
  assign w_dn_nx = w_all0 ? r_count : w_dn;
`else
  assign w_up_nx = w_up;
  assign w_dn_nx = w_dn;
`endif

  // Count register: clr > load > single-direction step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (load) begin
        r_count    <= w_ld;
        r_load_err <= |w_ld_bad;
      end else if (w_step_up) begin
        r_count <= w_up_nx;
        r_carry <= w_all9;
      end else if (w_step_dn) begin
        r_count  <= w_dn_nx;
        r_borrow <= w_all0;
      end
    end
  end

  assign count    = r_count;
  assign carry    = r_carry;
  assign borrow   = r_borrow;
  assign load_err = r_load_err;
  assign at_max   = &w_raw9;
  assign at_zero  = &w_raw0;

endmodule
